// File: rtl/wide_add_pkg.sv
// Shared constants and types for the word-serial wide adder.
// Imported by the controller and the adder slice.
package wide_add_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  function automatic int idx_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/adder_slice_32.sv
// One 32-bit ripple-carry slice of the wide adder.
// Also exposes the carry into bit 31 for signed overflow.
module adder_slice_32
  import wide_add_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout,
  output logic              c31
);

  logic [WORD_W-1:0] lo;
  logic              msb_p;

  // Low 31 bits add separately so the carry into the MSB is visible.
  always_comb begin
    lo = {1'b0, a[WORD_W-2:0]}
       + {1'b0, b[WORD_W-2:0]}
       + {{(WORD_W-1){1'b0}}, cin};
    c31   = lo[WORD_W-1];
    msb_p = a[WORD_W-1] ^ b[WORD_W-1];
    sum   = {msb_p ^ c31, lo[WORD_W-2:0]};
    cout  = (a[WORD_W-1] & b[WORD_W-1])
          | (c31 & msb_p);
  end

endmodule

// File: rtl/wide_add_sequencer.sv
// WORDS x 32-bit add/subtract sequenced through one 32-bit slice.
// LSW first, one word per cycle, registered carry between words.
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter  int WORDS = 4,
  localparam int W     = WORDS * WORD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  input  logic         in_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         out_ovf,
  output logic         busy
);

  localparam int IDX_W = idx_w(WORDS);
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(WORDS - 1);

  typedef logic [WORDS-1:0][WORD_W-1:0] vec_t;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  vec_t             a_q, a_d;
  vec_t             b_q, b_d;
  vec_t             sum_q, sum_d;
  logic             cy_q, cy_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  logic [WORD_W-1:0] sl_sum;
  logic              sl_cout;
  logic              sl_c31;

  adder_slice_32 u_slice (
    .a    (a_q[idx_q]),
    .b    (b_q[idx_q]),
    .cin  (cy_q),
    .sum  (sl_sum),
    .cout (sl_cout),
    .c31  (sl_c31)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cy_d    = cy_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtract is A + ~B + 1.
          a_d     = in_a;
          b_d     = in_b ^ {W{in_sub}};
          cy_d    = in_sub ? 1'b1 : in_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q] = sl_sum;
        cy_d         = sl_cout;
        idx_d        = idx_q + 1'b1;
        if (idx_q == LAST) begin
          cout_d  = sl_cout;
          ovf_d   = sl_c31 ^ sl_cout;
          valid_d = 1'b1;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cy_q    <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cy_q    <= cy_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench for wide_add_sequencer, WORDS=4.
// Expected values are hand-computed constants.
module tb_wide_add_sequencer;

  localparam int WORDS = 4;
  localparam int W     = WORDS * 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         in_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         busy;

  int checks = 0;
  int errors = 0;

  localparam logic [W-1:0] ONES = {W{1'b1}};
  localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] LO96 = {32'h0, {96{1'b1}}};
  localparam logic [W-1:0] B96  = {32'h1, 96'h0};

  wide_add_sequencer #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          input logic cin,
                          input logic sub);
    int n;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Cycle 0 is the handshake cycle; returns the cycle out_valid is seen.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!out_valid) chk("done_timeout", 0, 1);
  endtask

  task automatic run_op(input string tag,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic cin,
                        input logic sub,
                        input logic [W-1:0] es,
                        input logic ec,
                        input logic eo,
                        output int lat);
    out_ready = 1'b1;
    start_op(a, b, cin, sub);
    wait_done(lat);
    chk({tag, "_sum"}, out_sum, es);
    chk({tag, "_cout"}, W'(out_cout), W'(ec));
    chk({tag, "_ovf"}, W'(out_ovf), W'(eo));
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    int seen;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", W'(in_ready), 1);
    chk("rst_out_valid", W'(out_valid), 0);
    chk("rst_busy", W'(busy), 0);
    chk("rst_sum", out_sum, 0);
    chk("rst_cout", W'(out_cout), 0);
    chk("rst_ovf", W'(out_ovf), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("wrap", ONES, 1, 0, 0, 0, 1, 0, lat);
    chk("latency", W'(lat), 5);
    run_op("sub_borrow", 0, 1, 0, 1, ONES, 0, 0, lat);
    run_op("sovf", SMAX, 1, 0, 0, SMIN, 0, 1, lat);
    run_op("xcarry", LO96, 0, 1, 0, B96, 0, 0, lat);
    run_op("sub_ok", 5, 3, 0, 1, 2, 1, 0, lat);
    run_op("sub_neg_ovf", SMIN, 1, 0, 1, SMAX, 1, 1,
           lat);
    run_op("cin_ign", 10, 3, 1, 1, 7, 1, 0, lat);

    // Backpressure in DONE with a new request pending.
    out_ready = 1'b0;
    start_op(5, 3, 0, 1);
    wait_done(lat);
    in_a     = 100;
    in_b     = 23;
    in_cin   = 1'b1;
    in_sub   = 1'b0;
    in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_valid", W'(out_valid), 1);
      chk("bp_in_ready", W'(in_ready), 0);
      chk("bp_sum", out_sum, 2);
      chk("bp_cout", W'(out_cout), 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_drop_valid", W'(out_valid), 0);
    chk("bp_not_taken", W'(busy), 0);
    @(posedge clk); #1;
    chk("bp_next_taken", W'(busy), 1);
    in_valid = 1'b0;
    wait_done(lat);
    chk("bp_next_lat", W'(lat), 5);
    chk("bp_next_sum", out_sum, 124);
    @(posedge clk); #1;

    // Reset while RUN is on word index 2.
    out_ready = 1'b1;
    start_op(ONES, 1, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", W'(in_ready), 1);
    chk("mid_rst_busy", W'(busy), 0);
    chk("mid_rst_valid", W'(out_valid), 0);
    chk("mid_rst_sum", out_sum, 0);
    chk("mid_rst_cout", W'(out_cout), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen++;
    end
    chk("no_stale", W'(seen), 0);
    run_op("post_rst", 32'hFFFF_FFFF, 1, 0, 0,
           {95'h0, 1'b1, 32'h0}, 0, 0, lat);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
